// File: rtl/cycle_sequencer.sv
// T-state sequencer and interrupt arbiter feeding the instruction decoder.
// Owns the cycle counter and current instruction; forces 8'h00 on reset/NMI/IRQ entry.
module cycle_sequencer #(
    parameter int CYC_W   = 3,
    parameter int MAX_CYC = 7,
    parameter int NIRQ    = 4,
    parameter int IDW     = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             rdy,
    input  logic             icyc,
    input  logic             rcyc,
    input  logic [7:0]       opcode_in,
    input  logic             nmi,
    input  logic [NIRQ-1:0]  irq,
    input  logic [NIRQ-1:0]  irq_en,
    input  logic             idis,
    output logic [7:0]       inst,
    output logic [CYC_W-1:0] cycle,
    output logic             sync,
    output logic [1:0]       int_src,
    output logic [IDW-1:0]   irq_id,
    output logic             cyc_err
);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_RST  = 2'b01;
    localparam logic [1:0] SRC_NMI  = 2'b10;
    localparam logic [1:0] SRC_IRQ  = 2'b11;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYC);

    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic [7:0]       inst_q, inst_d;
    logic [1:0]       int_src_q, int_src_d;
    logic [IDW-1:0]   irq_id_q, irq_id_d;
    logic             sync_q, sync_d;
    logic             cyc_err_q, cyc_err_d;
    logic             nmi_lat_q, nmi_lat_d;
    logic             nmi_dly_q, nmi_dly_d;

    logic             nmi_rise;
    logic [NIRQ-1:0]  irq_req;
    logic             irq_any;
    logic [IDW-1:0]   irq_sel;

    always_comb begin
        irq_req = irq & irq_en & {NIRQ{~idis}};
        irq_any = |irq_req;
        irq_sel = '0;
        // Scan downward so the lowest pending channel wins
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq_req[i]) irq_sel = IDW'(i);
        end
    end

    always_comb begin
        cycle_d   = cycle_q;
        inst_d    = inst_q;
        int_src_d = int_src_q;
        irq_id_d  = irq_id_q;
        sync_d    = sync_q;
        cyc_err_d = cyc_err_q;
        nmi_dly_d = nmi;
        nmi_rise  = nmi & ~nmi_dly_q;
        nmi_lat_d = nmi_lat_q | nmi_rise;

        if (rdy) begin
            if (rcyc) begin
                cycle_d = '0;
                sync_d  = 1'b1;
                if (nmi_lat_q) begin
                    inst_d    = 8'h00;
                    int_src_d = SRC_NMI;
                    // A fresh edge arriving as the latch is consumed stays pending
                    nmi_lat_d = nmi_rise;
                end else if (irq_any) begin
                    inst_d    = 8'h00;
                    int_src_d = SRC_IRQ;
                    irq_id_d  = irq_sel;
                end else begin
                    inst_d    = opcode_in;
                    int_src_d = SRC_NONE;
                    irq_id_d  = '0;
                end
            end else begin
                sync_d = 1'b0;
                if (icyc) begin
                    if (cycle_q == LAST_CYC) begin
                        cyc_err_d = 1'b1;
                    end else begin
                        cycle_d = cycle_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cycle_q   <= '0;
            inst_q    <= 8'h00;
            int_src_q <= SRC_RST;
            irq_id_q  <= '0;
            sync_q    <= 1'b1;
            cyc_err_q <= 1'b0;
            nmi_lat_q <= 1'b0;
            nmi_dly_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            inst_q    <= inst_d;
            int_src_q <= int_src_d;
            irq_id_q  <= irq_id_d;
            sync_q    <= sync_d;
            cyc_err_q <= cyc_err_d;
            nmi_lat_q <= nmi_lat_d;
            nmi_dly_q <= nmi_dly_d;
        end
    end

    assign inst    = inst_q;
    assign cycle   = cycle_q;
    assign sync    = sync_q;
    assign int_src = int_src_q;
    assign irq_id  = irq_id_q;
    assign cyc_err = cyc_err_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: a reference model predicts every
// registered output after each edge; a monitor compares just after the edge.
module tb_cycle_sequencer;

    logic       clk = 1'b0;
    logic       clr, rdy, icyc, rcyc, nmi, idis;
    logic [7:0] opcode_in;
    logic [3:0] irq, irq_en;
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       sync;
    logic [1:0] int_src;
    logic [1:0] irq_id;
    logic       cyc_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int inst;
        int cycle;
        int sync;
        int src;
        int id;
        int err;
    } exp_t;

    exp_t sb[$];

    cycle_sequencer #(.CYC_W(3), .MAX_CYC(7), .NIRQ(4), .IDW(2)) dut (
        .clk(clk), .clr(clr), .rdy(rdy), .icyc(icyc), .rcyc(rcyc),
        .opcode_in(opcode_in), .nmi(nmi), .irq(irq), .irq_en(irq_en),
        .idis(idis), .inst(inst), .cycle(cycle), .sync(sync),
        .int_src(int_src), .irq_id(irq_id), .cyc_err(cyc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what an observer of the pins expects, from the rules
    initial begin : model
        int  m_inst, m_cycle, m_sync, m_src, m_id, m_err;
        bit  pend, prev_nmi, edge_seen;
        exp_t e;
        m_inst = 0; m_cycle = 0; m_sync = 1; m_src = 1; m_id = 0; m_err = 0;
        pend = 0; prev_nmi = 0;
        forever begin
            @(posedge clk);
            if (clr) begin
                m_inst = 0; m_cycle = 0; m_sync = 1; m_src = 1; m_id = 0;
                m_err = 0; pend = 0; prev_nmi = 0;
            end else begin
                edge_seen = nmi && !prev_nmi;
                prev_nmi  = nmi;
                if (rdy && rcyc) begin
                    int winner;
                    winner = -1;
                    for (int k = 0; k < 4; k++)
                        if (winner < 0 && irq[k] && irq_en[k] && !idis) winner = k;
                    m_cycle = 0;
                    m_sync  = 1;
                    if (pend) begin
                        m_inst = 0; m_src = 2;
                        pend = edge_seen;
                    end else begin
                        if (winner >= 0) begin
                            m_inst = 0; m_src = 3; m_id = winner;
                        end else begin
                            m_inst = opcode_in; m_src = 0; m_id = 0;
                        end
                        pend = edge_seen;
                    end
                end else begin
                    if (rdy) begin
                        m_sync = 0;
                        if (icyc) begin
                            if (m_cycle >= 7) m_err = 1;
                            else m_cycle = m_cycle + 1;
                        end
                    end
                    pend = pend || edge_seen;
                end
            end
            e.inst = m_inst; e.cycle = m_cycle; e.sync = m_sync;
            e.src = m_src; e.id = m_id; e.err = m_err;
            sb.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("inst",    int'(inst),    e.inst);
                chk("cycle",   int'(cycle),   e.cycle);
                chk("sync",    int'(sync),    e.sync);
                chk("int_src", int'(int_src), e.src);
                chk("irq_id",  int'(irq_id),  e.id);
                chk("cyc_err", int'(cyc_err), e.err);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_dec(input bit i, input bit r);
        icyc = i;
        rcyc = r;
    endtask

    initial begin : driver
        clr = 1; rdy = 1; icyc = 0; rcyc = 0; nmi = 0; idis = 0;
        opcode_in = 8'h00; irq = 4'h0; irq_en = 4'h0;
        tick(3);
        clr = 0;
        // reset sequence walks 0..7, then fetch 8'h69
        set_dec(1, 0); tick(7);
        opcode_in = 8'h69;
        set_dec(0, 1); tick(1);
        set_dec(1, 0); tick(3);
        // NMI edge mid-instruction, held high with irq[2] pending
        nmi = 1; irq = 4'b0100; irq_en = 4'b1111;
        set_dec(1, 0); tick(2);
        set_dec(0, 1); tick(1);
        set_dec(1, 0); tick(4);
        set_dec(0, 1); tick(1);
        set_dec(1, 0); tick(10);
        set_dec(0, 1); tick(1);
        nmi = 0; irq = 4'b1010; irq_en = 4'b1110; idis = 0;
        set_dec(1, 0); tick(2);
        set_dec(0, 1); tick(1);
        idis = 1; opcode_in = 8'hA9;
        set_dec(1, 0); tick(1);
        set_dec(0, 1); tick(1);
        // stall with an NMI edge arriving while frozen
        idis = 0; irq = 4'h0;
        rdy = 0; set_dec(1, 0); tick(2);
        nmi = 1; tick(3);
        rdy = 1; set_dec(1, 0); tick(1);
        set_dec(0, 1); tick(1);
        // run past the last cycle, then reset mid-instruction
        nmi = 0; opcode_in = 8'h4C;
        set_dec(0, 1); tick(1);
        set_dec(1, 0); tick(10);
        set_dec(0, 0); tick(2);
        set_dec(0, 1); tick(1);
        set_dec(1, 0); tick(4);
        clr = 1; tick(1);
        clr = 0; tick(1);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            clr       = ($urandom_range(0, 99) == 0);
            rdy       = ($urandom_range(0, 99) < 85);
            rcyc      = ($urandom_range(0, 99) < 20);
            icyc      = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 9) == 0) nmi = ~nmi;
            irq       = 4'($urandom);
            irq_en    = 4'($urandom);
            idis      = ($urandom_range(0, 3) == 0);
            opcode_in = 8'($urandom);
            tick(1);
        end
        clr = 0; rdy = 1; set_dec(0, 0);
        tick(3);
        chk("scoreboard_drain", sb.size() > 1 ? sb.size() : 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
